pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core: stall/flush control,
// Tuse/Tnew ageing, PC-preserving bubbles. Define PIPE_REG_EXC_EN to carry BD/ExcCode.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 N_LANE   = 4,
  parameter int                 TW       = 2,
  parameter bit                 DECR     = 1'b1,
  parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(32'h0000_3000)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     keep_pc,
  input  logic                     valid_d,
  input  logic [DATA_W-1:0]        ins_d,
  input  logic [DATA_W-1:0]        pc_d,
  input  logic [4:0]               a3_d,
  input  logic [TW-1:0]            tuse_rs_d,
  input  logic [TW-1:0]            tuse_rt_d,
  input  logic [TW-1:0]            tnew_d,
  input  logic [N_LANE*DATA_W-1:0] lane_d,
  input  logic                     bd_d,
  input  logic [4:0]               exc_d,
  input  logic [4:0]               exc_local,
  output logic                     valid_q,
  output logic [DATA_W-1:0]        ins_q,
  output logic [DATA_W-1:0]        pc_q,
  output logic [4:0]               a3_q,
  output logic [TW-1:0]            tuse_rs_q,
  output logic [TW-1:0]            tuse_rt_q,
  output logic [TW-1:0]            tnew_q,
  output logic [N_LANE*DATA_W-1:0] lane_q,
  output logic                     bd_q,
  output logic [4:0]               exc_q,
  output logic [7:0]               stall_cnt
);

  // Saturating age step; the F/D instance passes timing counters through untouched.
  function automatic logic [TW-1:0] age(input logic [TW-1:0] x);
    if (!DECR) return x;
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  logic                     valid_nx;
  logic [DATA_W-1:0]        ins_nx;
  logic [DATA_W-1:0]        pc_nx;
  logic [4:0]               a3_nx;
  logic [TW-1:0]            tuse_rs_nx;
  logic [TW-1:0]            tuse_rt_nx;
  logic [TW-1:0]            tnew_nx;
  logic [N_LANE*DATA_W-1:0] lane_nx;
  logic [7:0]               stall_cnt_d;
  logic [7:0]               stall_cnt_q;

  always_comb begin
    valid_nx    = valid_q;
    ins_nx      = ins_q;
    pc_nx       = pc_q;
    a3_nx       = a3_q;
    tuse_rs_nx  = tuse_rs_q;
    tuse_rt_nx  = tuse_rt_q;
    tnew_nx     = tnew_q;
    lane_nx     = lane_q;
    stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
    if (flush) begin
      valid_nx    = 1'b0;
      ins_nx      = '0;
      pc_nx       = keep_pc ? pc_d : RESET_PC;
      a3_nx       = '0;
      tuse_rs_nx  = '1;
      tuse_rt_nx  = '1;
      tnew_nx     = '0;
      lane_nx     = '0;
      stall_cnt_d = '0;
    end else if (en) begin
      valid_nx    = valid_d;
      ins_nx      = ins_d;
      pc_nx       = pc_d;
      a3_nx       = a3_d;
      tuse_rs_nx  = age(tuse_rs_d);
      tuse_rt_nx  = age(tuse_rt_d);
      tnew_nx     = age(tnew_d);
      lane_nx     = lane_d;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      ins_q       <= '0;
      pc_q        <= RESET_PC;
      a3_q        <= '0;
      tuse_rs_q   <= '1;
      tuse_rt_q   <= '1;
      tnew_q      <= '0;
      lane_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_nx;
      ins_q       <= ins_nx;
      pc_q        <= pc_nx;
      a3_q        <= a3_nx;
      tuse_rs_q   <= tuse_rs_nx;
      tuse_rt_q   <= tuse_rt_nx;
      tnew_q      <= tnew_nx;
      lane_q      <= lane_nx;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_REG_EXC_EN
  logic       bd_nx;
  logic [4:0] exc_nx;

  // Upstream exception is older, so it wins over one raised in this stage.
  always_comb begin
    bd_nx  = bd_q;
    exc_nx = exc_q;
    if (flush) begin
      bd_nx  = keep_pc ? bd_d : 1'b0;
      exc_nx = '0;
    end else if (en) begin
      bd_nx  = bd_d;
      exc_nx = (exc_d != 5'd0) ? exc_d : exc_local;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bd_q  <= 1'b0;
      exc_q <= '0;
    end else begin
      bd_q  <= bd_nx;
      exc_q <= exc_nx;
    end
  end
`else
  logic unused_exc;
  assign unused_exc = ^{bd_d, exc_d, exc_local};
  assign bd_q       = 1'b0;
  assign exc_q      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues hand-computed expected state
// after each edge; the monitor pops and compares on the falling edge (or on demand).
module tb_pipe_stage_reg;

`ifdef PIPE_REG_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  typedef struct packed {
    logic         valid;
    logic [31:0]  ins;
    logic [31:0]  pc;
    logic [4:0]   a3;
    logic [1:0]   trs;
    logic [1:0]   trt;
    logic [1:0]   tnew;
    logic [127:0] lane;
    logic         bd;
    logic [4:0]   exc;
    logic [7:0]   stall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         en = 1'b0, flush = 1'b0, keep_pc = 1'b0;
  logic         valid_d = 1'b0;
  logic [31:0]  ins_d = '0, pc_d = '0;
  logic [4:0]   a3_d = '0;
  logic [1:0]   tuse_rs_d = '0, tuse_rt_d = '0, tnew_d = '0;
  logic [127:0] lane_d = '0;
  logic         bd_d = 1'b0;
  logic [4:0]   exc_d = '0, exc_local = '0;
  logic         valid_q, bd_q;
  logic [31:0]  ins_q, pc_q;
  logic [4:0]   a3_q, exc_q;
  logic [1:0]   tuse_rs_q, tuse_rt_q, tnew_q;
  logic [127:0] lane_q;
  logic [7:0]   stall_cnt;

  pipe_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .keep_pc(keep_pc),
    .valid_d(valid_d), .ins_d(ins_d), .pc_d(pc_d), .a3_d(a3_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .tnew_d(tnew_d), .lane_d(lane_d),
    .bd_d(bd_d), .exc_d(exc_d), .exc_local(exc_local),
    .valid_q(valid_q), .ins_q(ins_q), .pc_q(pc_q), .a3_q(a3_q),
    .tuse_rs_q(tuse_rs_q), .tuse_rt_q(tuse_rt_q), .tnew_q(tnew_q), .lane_q(lane_q),
    .bd_q(bd_q), .exc_q(exc_q), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   txn = 0;
  exp_t exp_q[$];
  event chk_ev;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s (txn %0d): got %0h want %0h", nm, txn, act, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("valid", 128'(valid_q), 128'(e.valid));
        chk("ins", 128'(ins_q), 128'(e.ins));
        chk("pc", 128'(pc_q), 128'(e.pc));
        chk("a3", 128'(a3_q), 128'(e.a3));
        chk("tuse_rs", 128'(tuse_rs_q), 128'(e.trs));
        chk("tuse_rt", 128'(tuse_rt_q), 128'(e.trt));
        chk("tnew", 128'(tnew_q), 128'(e.tnew));
        chk("lane", lane_q, e.lane);
        chk("bd", 128'(bd_q), 128'(e.bd));
        chk("exc", 128'(exc_q), 128'(e.exc));
        chk("stall_cnt", 128'(stall_cnt), 128'(e.stall));
        $display("txn %0d t=%0t pc=%h valid=%0b stall=%0d", txn, $time, pc_q, valid_q, stall_cnt);
      end
    end
  end

  function automatic exp_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [4:0] a3, input logic [1:0] trs, input logic [1:0] trt,
                              input logic [1:0] tn, input logic [127:0] ln, input logic bd,
                              input logic [4:0] exc, input logic [7:0] st);
    exp_t e;
    e = '{valid:v, ins:ins, pc:pc, a3:a3, trs:trs, trt:trt, tnew:tn, lane:ln, bd:bd, exc:exc, stall:st};
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [4:0] a3, input logic [1:0] trs, input logic [1:0] trt,
                        input logic [1:0] tn, input logic [127:0] ln, input logic bd,
                        input logic [4:0] ed, input logic [4:0] el);
    valid_d = v; ins_d = ins; pc_d = pc; a3_d = a3;
    tuse_rs_d = trs; tuse_rt_d = trt; tnew_d = tn; lane_d = ln;
    bd_d = bd; exc_d = ed; exc_local = el;
  endtask

  task automatic ctl(input logic e, input logic f, input logic k);
    en = e; flush = f; keep_pc = k;
  endtask

  // One clock: expectation describes the state right after this rising edge.
  task automatic step(input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    logic [127:0] la, lb, lc, ld;
    exp_t r, ea, eb, ec, ed, eh;
    la = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    lb = {32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D};
    lc = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
    ld = {32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    r  = mk(1'b0, 32'h0, 32'h3000, 5'd0, 2'b11, 2'b11, 2'd0, 128'h0, 1'b0, 5'd0, 8'd0);

    // Reset takes effect before any clock edge.
    #1 reset_n = 1'b0;
    #2 exp_q.push_back(r); -> chk_ev;
    @(posedge clk); #1 reset_n = 1'b1;

    // Advance: saturating decrement, local exception picked up.
    set_in(1'b1, 32'h8C43_0004, 32'h3004, 5'd3, 2'd0, 2'd3, 2'd2, la, 1'b0, 5'd0, 5'd4);
    ctl(1'b1, 1'b0, 1'b0);
    ea = mk(1'b1, 32'h8C43_0004, 32'h3004, 5'd3, 2'd0, 2'd2, 2'd1, la, 1'b0, EXC ? 5'd4 : 5'd0, 8'd0);
    step(ea);

    // Upstream exception beats the local one.
    set_in(1'b1, 32'h1000_FFFF, 32'h3008, 5'd31, 2'd1, 2'd1, 2'd3, lb, 1'b1, 5'd12, 5'd4);
    eb = mk(1'b1, 32'h1000_FFFF, 32'h3008, 5'd31, 2'd0, 2'd0, 2'd2, lb, EXC, EXC ? 5'd12 : 5'd0, 8'd0);
    step(eb);

    // Stall 3 cycles with changing inputs: nothing moves, counter climbs.
    set_in(1'b0, 32'hFFFF_FFFF, 32'h7777, 5'd9, 2'd3, 2'd3, 2'd3, lc, 1'b0, 5'd7, 5'd7);
    ctl(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      eh = eb; eh.stall = 8'(i);
      step(eh);
    end

    // Resume: tnew already 0 stays 0, stall_cnt clears.
    set_in(1'b1, 32'h2402_0007, 32'h300C, 5'd2, 2'd2, 2'd0, 2'd0, lc, 1'b0, 5'd0, 5'd0);
    ctl(1'b1, 1'b0, 1'b0);
    ec = mk(1'b1, 32'h2402_0007, 32'h300C, 5'd2, 2'd1, 2'd0, 2'd0, lc, 1'b0, 5'd0, 8'd0);
    step(ec);

    // Bubble with en also high, PC/BD preserved.
    set_in(1'b1, 32'h0123_4567, 32'h3010, 5'd7, 2'd2, 2'd2, 2'd2, ld, 1'b1, 5'd9, 5'd3);
    ctl(1'b1, 1'b1, 1'b1);
    step(mk(1'b0, 32'h0, 32'h3010, 5'd0, 2'b11, 2'b11, 2'd0, 128'h0, EXC, 5'd0, 8'd0));

    // Bubble without PC preservation.
    pc_d = 32'h3014;
    ctl(1'b0, 1'b1, 1'b0);
    step(r);

    // Advance, then a long stall to exercise saturation at 255.
    set_in(1'b1, 32'hAC85_0008, 32'h3018, 5'd0, 2'd3, 2'd3, 2'd1, ld, 1'b0, 5'd0, 5'd0);
    ctl(1'b1, 1'b0, 1'b0);
    ed = mk(1'b1, 32'hAC85_0008, 32'h3018, 5'd0, 2'd2, 2'd2, 2'd0, ld, 1'b0, 5'd0, 8'd0);
    step(ed);
    ctl(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 257; i++) begin
      eh = ed; eh.stall = (i > 255) ? 8'd255 : 8'(i);
      step(eh);
    end
    ctl(1'b1, 1'b0, 1'b0);
    step(ed);

    // Stall to 10, then drop reset between edges.
    ctl(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      eh = ed; eh.stall = 8'(i);
      step(eh);
    end
    @(negedge clk); #2 reset_n = 1'b0;
    #1 exp_q.push_back(r); -> chk_ev;
    ctl(1'b1, 1'b0, 1'b0);
    step(r);
    reset_n = 1'b1;

    // First advance after reset release.
    set_in(1'b1, 32'h8C43_0004, 32'h3004, 5'd3, 2'd0, 2'd3, 2'd2, la, 1'b0, 5'd0, 5'd4);
    step(ea);
    ctl(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
